store_rmw_unit: RTL and testbench

Sequences memory stores for the multicycle datapath. It sits between the memory and the store-size merge stage. For sb/sh it reads the target word, latches it as the data-register value that feeds the merge stage, then writes the merged word back. sw bypasses the read, and the merge stage passes B through unchanged. The control unit starts it with a one-cycle pulse and waits for done.

---
 rtl/store_rmw_unit.sv | 166 ++++++++++++++++
 tb/tb_store_rmw_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: store sequencer for the multicycle datapath.
// sb/sh read the target word, hand it to the store-size merge stage, and
// write the merged word back; sw skips the read; type 11 completes with
// no memory access.
// Optional macro STORE_ALIGN_CHECK_EN rejects a misaligned sh/sw with an
// align_err pulse; without it align_err is tied to 0.
module store_rmw_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       mem_data_in,
    input  logic [31:0]       ss_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       data_reg_out,
    output logic [1:0]        controle_ss,
    output logic              busy,
    output logic              done,
    output logic              align_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          type_q, type_d;
    logic [3:0]          rd_cnt_q, rd_cnt_d;
    logic [31:0]         data_reg_q, data_reg_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef STORE_ALIGN_CHECK_EN
    logic                align_q, align_d;
    logic                misaligned;
`endif

    // Register every piece of sequencing state; reset returns to IDLE with all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            type_q     <= 2'b00;
            rd_cnt_q   <= 4'd0;
            data_reg_q <= 32'd0;
            wdata_q    <= 32'd0;
`ifdef STORE_ALIGN_CHECK_EN
            align_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            rd_cnt_q   <= rd_cnt_d;
            data_reg_q <= data_reg_d;
            wdata_q    <= wdata_d;
`ifdef STORE_ALIGN_CHECK_EN
            align_q    <= align_d;
`endif
        end
    end

`ifdef STORE_ALIGN_CHECK_EN
    // A halfword must sit on an even address and a word on a 4-byte boundary.
    always_comb begin
        misaligned = 1'b0;
        if (store_type == 2'b10 && addr_in[0])
            misaligned = 1'b1;
        if (store_type == 2'b00 && addr_in[1:0] != 2'b00)
            misaligned = 1'b1;
    end
`endif

    // Next-state logic: walk READ -> CAPTURE -> MERGE -> WRITE -> DONE as the store type requires.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        rd_cnt_d   = rd_cnt_q;
        data_reg_d = data_reg_q;
        wdata_d    = wdata_q;
`ifdef STORE_ALIGN_CHECK_EN
        align_d    = align_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = addr_in;
                    type_d = store_type;
`ifdef STORE_ALIGN_CHECK_EN
                    align_d = 1'b0;
`endif
                    case (store_type)
                        2'b00:   state_d = MERGE;
                        2'b01,
                        2'b10: begin
                            state_d  = READ;
                            rd_cnt_d = 4'(READ_LATENCY);
                        end
                        default: state_d = DONE;
                    endcase
`ifdef STORE_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d  = DONE;
                        rd_cnt_d = rd_cnt_q;
                        align_d  = 1'b1;
                    end
`endif
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q <= 4'd1)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                data_reg_d = mem_data_in;
                state_d    = MERGE;
            end
            MERGE: begin
                wdata_d = ss_out;
                state_d = WRITE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state so nothing glitches off the inputs.
    always_comb begin
        mem_addr     = '0;
        mem_wr       = 1'b0;
        mem_wdata    = 32'd0;
        controle_ss  = 2'b00;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        data_reg_out = data_reg_q;
        if (state_q != IDLE) begin
            mem_addr = addr_q;
            if (type_q != 2'b11)
                controle_ss = type_q;
        end
        if (state_q == WRITE) begin
            mem_wr    = 1'b1;
            mem_wdata = wdata_q;
        end
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign align_err = (state_q == DONE) && align_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: scoreboard bench for store_rmw_unit.
// Two instances run side by side: one with READ_LATENCY=1, one with 3.
// The bench models memory read latency and the store-size merge stage.
// Honours STORE_ALIGN_CHECK_EN for the alignment scenario.
module tb_store_rmw_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  store_type;
    logic [31:0] addr_in;
    logic [31:0] mem_data1, mem_data3, ss_out1, ss_out3;
    logic [31:0] mem_addr1, mem_wdata1, data_reg_out1;
    logic [31:0] mem_addr3, mem_wdata3, data_reg_out3;
    logic        mem_wr1, busy1, done1, align_err1;
    logic        mem_wr3, busy3, done3, align_err3;
    logic [1:0]  controle_ss1, controle_ss3;

    logic [31:0] mem_word1 = 32'h0, mem_word3 = 32'h0;
    logic [31:0] b_val1 = 32'h0, b_val3 = 32'h0;
    int          busy_cnt1 = 0, busy_cnt3 = 0;
    int          vectors = 0, miscompares = 0;
    wr_exp_t     exp_q[$];

    store_rmw_unit #(.READ_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .store_type(store_type),
        .addr_in(addr_in), .mem_data_in(mem_data1), .ss_out(ss_out1),
        .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
        .data_reg_out(data_reg_out1), .controle_ss(controle_ss1),
        .busy(busy1), .done(done1), .align_err(align_err1)
    );

    store_rmw_unit #(.READ_LATENCY(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .store_type(store_type),
        .addr_in(addr_in), .mem_data_in(mem_data3), .ss_out(ss_out3),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
        .data_reg_out(data_reg_out3), .controle_ss(controle_ss3),
        .busy(busy3), .done(done3), .align_err(align_err3)
    );

    always #5 clk = ~clk;

    // Count cycles since each unit went busy; read data is only valid READ_LATENCY cycles after the address.
    always @(posedge clk) begin
        busy_cnt1 <= busy1 ? busy_cnt1 + 1 : 0;
        busy_cnt3 <= busy3 ? busy_cnt3 + 1 : 0;
    end

    // Memory read model returns garbage until the latency has elapsed.
    always_comb begin
        mem_data1 = (busy1 && busy_cnt1 >= 1) ? mem_word1 : 32'hBAD0BAD0;
        mem_data3 = (busy3 && busy_cnt3 >= 3) ? mem_word3 : 32'hBAD0BAD0;
    end

    // Store-size merge stage: replace the low byte/halfword of the read word with B.
    always_comb begin
        case (controle_ss1)
            2'b01:   ss_out1 = {data_reg_out1[31:8], b_val1[7:0]};
            2'b10:   ss_out1 = {data_reg_out1[31:16], b_val1[15:0]};
            default: ss_out1 = b_val1;
        endcase
        case (controle_ss3)
            2'b01:   ss_out3 = {data_reg_out3[31:8], b_val3[7:0]};
            2'b10:   ss_out3 = {data_reg_out3[31:16], b_val3[15:0]};
            default: ss_out3 = b_val3;
        endcase
    end

    // Pulse start for one edge on the chosen unit; returns just after that edge.
    task automatic issue(input int which, input logic [1:0] t, input logic [31:0] a);
        @(negedge clk);
        store_type = t;
        addr_in    = a;
        if (which == 1) start1 = 1'b1;
        else            start3 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Hold reset two cycles and check everything comes up cleared.
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy1, mem_wr1, done1, align_err1} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags1 got %b expected 0000", {busy1, mem_wr1, done1, align_err1});
        end
        if ({busy3, mem_wr3, done3, align_err3} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags3 got %b expected 0000", {busy3, mem_wr3, done3, align_err3});
        end
        if (mem_addr1 !== 32'h0 || mem_wdata1 !== 32'h0 || data_reg_out1 !== 32'h0 || controle_ss1 !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_data1 got addr %h wdata %h dreg %h ss %b expected zeros",
                     mem_addr1, mem_wdata1, data_reg_out1, controle_ss1);
        end
    endtask

    // sw: no read, write at +2, done at +3.
    task automatic test_sw();
        wr_exp_t e;
        b_val1 = 32'hDEADBEEF;
        e.addr = 32'h100; e.data = 32'hDEADBEEF; e.cyc = 2;
        exp_q.push_back(e);
        issue(1, 2'b00, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_wr1 !== 1'(k == 2) || done1 !== 1'(k == 3) || busy1 !== 1'(k <= 3)) begin
                miscompares++;
                $display("[TB] FAIL sw_ctrl k=%0d got wr/done/busy %b%b%b expected %b%b%b",
                         k, mem_wr1, done1, busy1, k == 2, k == 3, k <= 3);
            end
            if (mem_addr1 !== ((k <= 3) ? 32'h100 : 32'h0) || controle_ss1 !== 2'b00 || data_reg_out1 !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL sw_addr k=%0d got addr %h ss %b dreg %h expected %h 00 0",
                         k, mem_addr1, controle_ss1, data_reg_out1, (k <= 3) ? 32'h100 : 32'h0);
            end
            if (mem_wr1 === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (k != e.cyc || mem_addr1 !== e.addr || mem_wdata1 !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL sw_write got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, mem_addr1, mem_wdata1, e.cyc, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sw_pending got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // sb with READ_LATENCY=1: capture visible from +3, write at +4, done at +5.
    task automatic test_sb();
        wr_exp_t e;
        mem_word1 = 32'h11223344;
        b_val1    = 32'h000000AA;
        e.addr = 32'h201; e.data = 32'h112233AA; e.cyc = 4;
        exp_q.push_back(e);
        issue(1, 2'b01, 32'h201);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_wr1 !== 1'(k == 4) || done1 !== 1'(k == 5) || busy1 !== 1'(k <= 5)) begin
                miscompares++;
                $display("[TB] FAIL sb_ctrl k=%0d got wr/done/busy %b%b%b expected %b%b%b",
                         k, mem_wr1, done1, busy1, k == 4, k == 5, k <= 5);
            end
            if (controle_ss1 !== ((k <= 5) ? 2'b01 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL sb_controle_ss k=%0d got %b expected %b", k, controle_ss1, (k <= 5) ? 2'b01 : 2'b00);
            end
            if (data_reg_out1 !== ((k >= 3) ? 32'h11223344 : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL sb_data_reg k=%0d got %h expected %h", k, data_reg_out1, (k >= 3) ? 32'h11223344 : 32'h0);
            end
            if (mem_wr1 === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (k != e.cyc || mem_addr1 !== e.addr || mem_wdata1 !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL sb_write got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, mem_addr1, mem_wdata1, e.cyc, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_pending got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // sh with READ_LATENCY=3: write at +6, done at +7, busy for 7 cycles.
    task automatic test_sh();
        wr_exp_t e;
        int busy_total;
        busy_total = 0;
        mem_word3  = 32'hCAFEF00D;
        b_val3     = 32'h00001234;
        e.addr = 32'h300; e.data = 32'hCAFE1234; e.cyc = 6;
        exp_q.push_back(e);
        issue(3, 2'b10, 32'h300);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            vectors++;
            if (busy3 === 1'b1) busy_total++;
            if (mem_wr3 !== 1'(k == 6) || done3 !== 1'(k == 7)) begin
                miscompares++;
                $display("[TB] FAIL sh_ctrl k=%0d got wr/done %b%b expected %b%b", k, mem_wr3, done3, k == 6, k == 7);
            end
            if (controle_ss3 !== ((k <= 7) ? 2'b10 : 2'b00) || mem_addr3 !== ((k <= 7) ? 32'h300 : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL sh_ss_addr k=%0d got ss %b addr %h", k, controle_ss3, mem_addr3);
            end
            if (data_reg_out3 !== ((k >= 5) ? 32'hCAFEF00D : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL sh_data_reg k=%0d got %h expected %h", k, data_reg_out3, (k >= 5) ? 32'hCAFEF00D : 32'h0);
            end
            if (mem_wr3 === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (k != e.cyc || mem_addr3 !== e.addr || mem_wdata3 !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL sh_write got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, mem_addr3, mem_wdata3, e.cyc, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (busy_total != 7 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sh_busy_len got %0d busy cycles, %0d pending expected 7, 0", busy_total, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reserved type 11: done at +1, no write, merge select stays 00.
    task automatic test_reserved();
        issue(1, 2'b11, 32'h500);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_wr1 !== 1'b0 || done1 !== 1'(k == 1) || busy1 !== 1'(k == 1) || controle_ss1 !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL reserved k=%0d got wr/done/busy %b%b%b ss %b expected 0%b%b 00",
                         k, mem_wr1, done1, busy1, controle_ss1, k == 1, k == 1);
            end
            if (mem_addr1 !== ((k == 1) ? 32'h500 : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL reserved_addr k=%0d got %h expected %h", k, mem_addr1, (k == 1) ? 32'h500 : 32'h0);
            end
        end
    endtask

    // start held high: each new sw begins only from IDLE, one op per 4 cycles.
    task automatic test_back_to_back();
        wr_exp_t e;
        b_val1 = 32'h0BADCAFE;
        for (int n = 0; n < 3; n++) begin
            e.addr = 32'h40; e.data = 32'h0BADCAFE; e.cyc = 2 + 4 * n;
            exp_q.push_back(e);
        end
        @(negedge clk);
        store_type = 2'b00;
        addr_in    = 32'h40;
        start1     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            vectors++;
            if (busy1 !== 1'(k <= 11 && (k % 4) != 0) || done1 !== 1'(k <= 11 && (k % 4) == 3)
                || mem_wr1 !== 1'(k <= 11 && (k % 4) == 2)) begin
                miscompares++;
                $display("[TB] FAIL b2b_ctrl k=%0d got busy/done/wr %b%b%b", k, busy1, done1, mem_wr1);
            end
            if (data_reg_out1 !== 32'h11223344) begin
                miscompares++;
                $display("[TB] FAIL b2b_data_reg k=%0d got %h expected 11223344", k, data_reg_out1);
            end
            if (mem_wr1 === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (k != e.cyc || mem_addr1 !== e.addr || mem_wdata1 !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_write got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, mem_addr1, mem_wdata1, e.cyc, e.addr, e.data);
                end
            end
            if (k == 12) start1 = 1'b0;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_pending got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Misaligned sh at 0x103: rejected with align_err when checking is built in, else a normal sh.
    task automatic test_align();
        wr_exp_t e;
        mem_word1 = 32'h55667788;
        b_val1    = 32'h0000ABCD;
`ifndef STORE_ALIGN_CHECK_EN
        e.addr = 32'h103; e.data = 32'h5566ABCD; e.cyc = 4;
        exp_q.push_back(e);
`endif
        issue(1, 2'b10, 32'h103);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
`ifdef STORE_ALIGN_CHECK_EN
            if (mem_wr1 !== 1'b0 || done1 !== 1'(k == 1) || align_err1 !== 1'(k == 1) || busy1 !== 1'(k == 1)) begin
                miscompares++;
                $display("[TB] FAIL align_reject k=%0d got wr/done/err/busy %b%b%b%b expected 0%b%b%b",
                         k, mem_wr1, done1, align_err1, busy1, k == 1, k == 1, k == 1);
            end
`else
            if (mem_wr1 !== 1'(k == 4) || done1 !== 1'(k == 5) || align_err1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL align_accept k=%0d got wr/done/err %b%b%b expected %b%b0",
                         k, mem_wr1, done1, align_err1, k == 4, k == 5);
            end
`endif
            if (mem_wr1 === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (k != e.cyc || mem_addr1 !== e.addr || mem_wdata1 !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL align_write got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             k, mem_addr1, mem_wdata1, e.cyc, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL align_pending got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset during READ of the latency-3 unit: IDLE at the next edge, data register cleared, no write afterwards.
    task automatic test_reset_mid();
        mem_word3 = 32'h99887766;
        issue(3, 2'b01, 32'h600);
        @(negedge clk);
        vectors++;
        if (busy3 !== 1'b1 || data_reg_out3 !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL midreset_pre got busy %b dreg %h expected 1 cafef00d", busy3, data_reg_out3);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy3 !== 1'b0 || mem_wr3 !== 1'b0 || data_reg_out3 !== 32'h0 || controle_ss3 !== 2'b00 || mem_addr3 !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_state got busy %b wr %b dreg %h ss %b addr %h expected 0 0 0 00 0",
                     busy3, mem_wr3, data_reg_out3, controle_ss3, mem_addr3);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_wr3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_after k=%0d got wr/busy/done %b%b%b expected 000", k, mem_wr3, busy3, done3);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start1     = 1'b0;
        start3     = 1'b0;
        store_type = 2'b00;
        addr_in    = 32'h0;
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_reserved();
        test_back_to_back();
        test_align();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
